mdu_unit: RTL and testbench

Multiply/divide unit in the E stage of the pipelined MIPS core, directly downstream of the R-type function decoder. It consumes the decoder's one-hot `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo`/`mfhi`/`mflo` strobes plus forwarded `rs`/`rt` operands. It owns the HI/LO registers and models fixed multi-cycle latency with a busy counter. It exports `start`/`busy` to the hazard unit and returns HI or LO for `mfhi`/`mflo`.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_calc.sv | 74 +++++++
 rtl/mdu_unit.sv | 116 +++++++++++
 tb/tb_mdu_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared latency defaults, op encoding and strobe priority encoder for the MDU
package mdu_pkg;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NONE  = 3'd6
    } md_op_e;

    // Fixed priority: mult > multu > div > divu > mthi > mtlo.
    function automatic md_op_e md_decode(input logic mult, input logic multu,
                                         input logic div, input logic divu,
                                         input logic mthi, input logic mtlo);
        md_op_e op;
        if (mult)       op = MD_MULT;
        else if (multu) op = MD_MULTU;
        else if (div)   op = MD_DIV;
        else if (divu)  op = MD_DIVU;
        else if (mthi)  op = MD_MTHI;
        else if (mtlo)  op = MD_MTLO;
        else            op = MD_NONE;
        return op;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational HI/LO result for one mult/div op; honours MDU_DIV0_HOLD_EN
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    md_op_e      op_e;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_a;
    logic [31:0] div_b;

    assign op_e = md_op_e'(op);

    always_comb begin
        prod   = '0;
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        a_neg  = (op_e == MD_DIV) & rs_val[31];
        b_neg  = (op_e == MD_DIV) & rt_val[31];
        a_mag  = a_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag  = b_neg ? (~rt_val + 32'd1) : rt_val;
        // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        div_a  = a_mag;
        div_b  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq     = div_a / div_b;
        ur     = div_a % div_b;
        case (op_e)
            MD_MULT: begin
                prod   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                prod   = {32'd0, rs_val} * {32'd0, rt_val};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                if (rt_val == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
                    res_wr = 1'b0;
`else
                    res_hi = rs_val;
                    res_lo = '1;
                    res_wr = 1'b1;
`endif
                end else begin
                    res_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
                    res_hi = a_neg ? (~ur + 32'd1) : ur;
                    res_wr = 1'b1;
                end
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed-latency busy counter
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] rd_data
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_op_e      op;
    logic        is_mul;
    logic        is_md;
    logic        acc;
    logic        mt_ok;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_wr;
    logic        unused_mflo;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic        p_wr_q, p_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    assign op     = md_decode(mult, multu, div, divu, mthi, mtlo);
    assign is_mul = (op == MD_MULT) | (op == MD_MULTU);
    assign is_md  = is_mul | (op == MD_DIV) | (op == MD_DIVU);
    assign acc    = en & ~req & ~busy_q & is_md;
    assign mt_ok  = en & ~req & ~busy_q;
    assign start  = acc;
    assign busy   = busy_q;
    // Strobes are one-hot, so mflo is implied whenever mfhi is low.
    assign rd_data     = mfhi ? hi_q : lo_q;
    assign unused_mflo = mflo;

    mdu_calc u_calc (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (calc_hi),
        .res_lo (calc_lo),
        .res_wr (calc_wr)
    );

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        p_wr_d = p_wr_q;
        cnt_d  = cnt_q;
        busy_d = 1'b0;
        if (acc) begin
            p_hi_d = calc_hi;
            p_lo_d = calc_lo;
            p_wr_d = calc_wr;
            cnt_d  = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            busy_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
            // Result lands on the same edge busy drops, so a back-to-back reader sees it.
            if ((cnt_q == CNT_W'(1)) && p_wr_q) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
        end else if (mt_ok) begin
            if (op == MD_MTHI) hi_d = rs_val;
            if (op == MD_MTLO) lo_d = rs_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            p_wr_q <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            p_wr_q <= p_wr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - randomized self-checking bench for mdu_unit against an arithmetic HI/LO model
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, req;
    logic        mult, multu, div, divu, mthi, mtlo, mfhi, mflo;
    logic [31:0] rs_val, rt_val;
    logic        start, busy;
    logic [31:0] rd_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .mult    (mult),
        .multu   (multu),
        .div     (div),
        .divu    (divu),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mfhi    (mfhi),
        .mflo    (mflo),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .start   (start),
        .busy    (busy),
        .rd_data (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        mfhi = 1'b1;
        #1;
        chk({tag, "_hi"}, rd_data, m_hi);
        mfhi = 1'b0;
        mflo = 1'b1;
        #1;
        chk({tag, "_lo"}, rd_data, m_lo);
        mflo = 1'b0;
    endtask

    // s bit order: {mtlo, mthi, divu, div, multu, mult}
    task automatic run_op(input string tag, input logic [5:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic rq);
        int          op;
        logic        acc;
        logic [63:0] p;
        logic [63:0] tq, tr;
        longint      sa, sb, ua, ub;
        logic        r_wr;
        int          n;
        int          lat;
        op = 6;
        for (int i = 5; i >= 0; i--) if (s[i]) op = i;
        @(negedge clk);
        {mtlo, mthi, divu, div, multu, mult} = s;
        rs_val = a;
        rt_val = b;
        en     = 1'b1;
        req    = rq;
        #1;
        acc = (op < 4) && !rq;
        chk({tag, "_start"}, {31'd0, start}, {31'd0, acc});
        @(posedge clk);
        #1;
        {mtlo, mthi, divu, div, multu, mult} = 6'd0;
        en  = 1'b0;
        req = 1'b0;
        if (!rq && op == 4) m_hi = a;
        if (!rq && op == 5) m_lo = a;
        if (acc) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            ua   = longint'({32'd0, a});
            ub   = longint'({32'd0, b});
            r_wr = 1'b1;
            p    = '0;
            lat  = (op < 2) ? 5 : 10;
            if (op == 0) p = sa * sb;
            else if (op == 1) p = ua * ub;
            else if (b == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
                r_wr = 1'b0;
`else
                p = {a, 32'hFFFF_FFFF};
`endif
            end else begin
                tq = (op == 2) ? (sa / sb) : (ua / ub);
                tr = (op == 2) ? (sa % sb) : (ua % ub);
                p  = {tr[31:0], tq[31:0]};
            end
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                @(posedge clk);
                #1;
            end
            chk({tag, "_busy_cycles"}, n, lat);
            if (r_wr) begin
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
        end else begin
            chk({tag, "_no_busy"}, {31'd0, busy}, 32'd0);
        end
        check_hilo(tag);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] s;
        rst_n = 1'b0;
        en = 1'b0; req = 1'b0;
        {mtlo, mthi, divu, div, multu, mult} = 6'd0;
        mfhi = 1'b0; mflo = 1'b0;
        rs_val = '0; rt_val = '0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_start", {31'd0, start}, 32'd0);
        check_hilo("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult", 6'b000001, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("multu", 6'b000010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("div", 6'b000100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu", 6'b001000, 32'd7, 32'd2, 1'b0);
        run_op("div_ovf", 6'b000100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mthi", 6'b010000, 32'h0000_1234, 32'd0, 1'b0);
        run_op("mult_req", 6'b000001, 32'd3, 32'd4, 1'b1);
        run_op("mtlo_req", 6'b100000, 32'hDEAD_BEEF, 32'd0, 1'b1);
        run_op("prio", 6'b111100, 32'd100, 32'd7, 1'b0);
        run_op("pre_hi", 6'b010000, 32'h0000_000A, 32'd0, 1'b0);
        run_op("pre_lo", 6'b100000, 32'h0000_000B, 32'd0, 1'b0);
        run_op("div0", 6'b000100, 32'h0000_0055, 32'd0, 1'b0);
        run_op("divu0", 6'b001000, 32'h8000_0001, 32'd0, 1'b0);

        run_op("pre_rst", 6'b010000, 32'h0000_0077, 32'd0, 1'b0);
        @(negedge clk);
        mult = 1'b1; rs_val = 32'd9; rt_val = 32'd3; en = 1'b1;
        @(posedge clk);
        #1;
        mult = 1'b0; en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        m_hi = '0;
        m_lo = '0;
        check_hilo("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst_after");

        for (int k = 0; k < 40; k++) begin
            s = 6'd1 << $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) s = s | 6'($urandom);
            run_op("rnd", s, pick_val(), pick_val(), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
